agu_seq_ctrl: RTL and testbench

- Job-level sequencer and configurator for one address generation unit (AGU).
- Latches a job descriptor (loop lengths, jumps, total address count) on a start handshake and holds it stable on the AGU config ports for the whole job.
- Issues the AGU clear, then steps the AGU once per accepted address under downstream back-pressure. Signals last and done.
- Sits between the MVU control/instruction logic and the AGU feeding a memory read/write port.

---
 rtl/agu_seq_ctrl_if.sv | 52 +++++
 rtl/agu_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_agu_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/agu_seq_ctrl_if.sv
// agu_seq_ctrl_if: start/config handshake, AGU config/control and address
// handshake of the AGU job sequencer. master = sequencer side, slave = the
// surrounding control logic, AGU and downstream memory port.
// Optional: AGU_SEQ_WRAPCNT_EN adds the wrap_cnt status signal.
interface agu_seq_ctrl_if #(
  parameter int BWADDR   = 21,
  parameter int BWLENGTH = 8,
  parameter int NJUMPS   = 5,
  parameter int BWCOUNT  = 16
);
  // job request / descriptor
  logic                               start;
  logic                               start_rdy;
  logic [NJUMPS-1:1][BWLENGTH-1:0]    cfg_l;
  logic [NJUMPS-1:0][BWADDR-1:0]      cfg_j;
  logic [BWCOUNT-1:0]                 cfg_count;
  logic                               abort;
  // AGU configuration and control
  logic [NJUMPS-1:1][BWLENGTH-1:0]    agu_l;
  logic [NJUMPS-1:0][BWADDR-1:0]      agu_j;
  logic                               agu_clr;
  logic                               agu_step;
  logic                               agu_on_j0;
  // downstream address handshake
  logic                               addr_valid;
  logic                               addr_ready;
  logic                               addr_last;
  // status
  logic                               busy;
  logic                               done;
`ifdef AGU_SEQ_WRAPCNT_EN
  logic [BWCOUNT-1:0]                 wrap_cnt;
`endif

  modport master (
`ifdef AGU_SEQ_WRAPCNT_EN
    output wrap_cnt,
`endif
    input  start, cfg_l, cfg_j, cfg_count, abort, agu_on_j0, addr_ready,
    output start_rdy, agu_l, agu_j, agu_clr, agu_step, addr_valid,
           addr_last, busy, done
  );

  modport slave (
`ifdef AGU_SEQ_WRAPCNT_EN
    input  wrap_cnt,
`endif
    output start, cfg_l, cfg_j, cfg_count, abort, agu_on_j0, addr_ready,
    input  start_rdy, agu_l, agu_j, agu_clr, agu_step, addr_valid,
           addr_last, busy, done
  );
endinterface

// File: rtl/agu_seq_ctrl.sv
// agu_seq_ctrl: job-level sequencer/configurator for one AGU.
// Latency: 1 CLEAR + count RUN + 1 DONE cycles per job, 1 address/cycle.
// Backpressure: addr_ready=0 freezes the job and withholds agu_step.
// Ports: clk, rst (async, active high); io_ctl (agu_seq_ctrl_if.master)
// carrying start/cfg/abort, AGU l/j/clr/step/on_j0, addr valid/ready/last,
// busy/done. Optional macro AGU_SEQ_WRAPCNT_EN adds wrap_cnt (count of
// steps that coincided with the AGU outer wrap, saturating).
module agu_seq_ctrl #(
  parameter int BWADDR   = 21,
  parameter int BWLENGTH = 8,
  parameter int NJUMPS   = 5,
  parameter int BWCOUNT  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  agu_seq_ctrl_if.master       io_ctl
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [BWCOUNT-1:0]               r_rem;
  logic [NJUMPS-1:1][BWLENGTH-1:0]  r_agu_l;
  logic [NJUMPS-1:0][BWADDR-1:0]    r_agu_j;

  logic w_start_acc;
  logic w_start_rdy;
  logic w_clr;
  logic w_valid;
  logic w_last;
  logic w_busy;
  logic w_done;
  logic w_xfer;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and per-state outputs
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_start_rdy = 1'b0;
    w_clr       = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy      = 1'b0;
        w_start_rdy = 1'b1;
        // abort is meaningless here, so start always wins
        if (io_ctl.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (io_ctl.cfg_count == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_clr       = 1'b1;
        w_state_nxt = io_ctl.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (io_ctl.abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_valid = 1'b1;
          w_last  = (r_rem == BWCOUNT'(1));
          // the AGU still takes the final step; its new address is not shown
          if (io_ctl.addr_ready && w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // an aborted job never reports completion
        w_done      = ~io_ctl.abort;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_xfer = w_valid & io_ctl.addr_ready;

  // job descriptor and remaining-address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_agu_l <= '0;
      r_agu_j <= '0;
    end else if (w_start_acc) begin
      r_rem   <= io_ctl.cfg_count;
      r_agu_l <= io_ctl.cfg_l;
      r_agu_j <= io_ctl.cfg_j;
    end else if ((r_state != S_IDLE) && io_ctl.abort) begin
      // descriptor is kept on abort; only the count is dropped
      r_rem <= '0;
    end else if (w_xfer && (r_rem != '0)) begin
      r_rem <= r_rem - BWCOUNT'(1);
    end
  end

`ifdef AGU_SEQ_WRAPCNT_EN
  logic [BWCOUNT-1:0] r_wrap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_wrap_cnt <= '0;
    end else if (w_xfer && io_ctl.agu_on_j0 && (r_wrap_cnt != '1)) begin
      r_wrap_cnt <= r_wrap_cnt + BWCOUNT'(1);
    end
  end

  assign io_ctl.wrap_cnt = r_wrap_cnt;
`else
  // outer-wrap indication only feeds the optional wrap counter
  logic w_unused;
  assign w_unused = io_ctl.agu_on_j0;
`endif

  assign io_ctl.start_rdy  = w_start_rdy;
  assign io_ctl.agu_l      = r_agu_l;
  assign io_ctl.agu_j      = r_agu_j;
  assign io_ctl.agu_clr    = w_clr;
  assign io_ctl.agu_step   = w_xfer;
  assign io_ctl.addr_valid = w_valid;
  assign io_ctl.addr_last  = w_last;
  assign io_ctl.busy       = w_busy;
  assign io_ctl.done       = w_done;

endmodule

// File: tb/tb_agu_seq_ctrl.sv
// tb_agu_seq_ctrl: directed scenarios plus randomized traffic for
// agu_seq_ctrl, checked every cycle against a job-level reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_agu_seq_ctrl;
  localparam int BWA = 21;
  localparam int BWL = 8;
  localparam int NJ  = 5;
  localparam int BWC = 16;

  logic clk;
  logic rst;

  agu_seq_ctrl_if #(.BWADDR(BWA), .BWLENGTH(BWL), .NJUMPS(NJ), .BWCOUNT(BWC)) u_if ();

  agu_seq_ctrl #(.BWADDR(BWA), .BWLENGTH(BWL), .NJUMPS(NJ), .BWCOUNT(BWC)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_ctl (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: job in flight, clear owed, addresses left, finish owed
  bit                          m_busy;
  bit                          m_clr;
  bit                          m_fin;
  int                          m_left;
  int                          m_wrap;
  logic [NJ-1:1][BWL-1:0]      m_l;
  logic [NJ-1:0][BWA-1:0]      m_j;

  int n_chk;
  int n_fail;
  // per-scenario statistics
  int cyc;
  int s_busy, s_xfer, s_clr, s_done, s_valid, s_last_idx, s_last_cyc, s_done_cyc;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_clr = 0; m_fin = 0; m_left = 0; m_wrap = 0;
    m_l = '0; m_j = '0;
  endtask

  task automatic clr_stats();
    s_busy = 0; s_xfer = 0; s_clr = 0; s_done = 0; s_valid = 0;
    s_last_idx = -1; s_last_cyc = -1; s_done_cyc = -1;
  endtask

  task automatic model_update();
    if (!m_busy) begin
      if (u_if.start) begin
        m_l    = u_if.cfg_l;
        m_j    = u_if.cfg_j;
        m_left = int'(u_if.cfg_count);
        m_busy = 1;
        m_clr  = (m_left != 0);
        m_fin  = (m_left == 0);
      end
    end else if (u_if.abort) begin
      if (m_clr) m_wrap = 0;
      m_busy = 0; m_clr = 0; m_fin = 0; m_left = 0;
    end else if (m_clr) begin
      m_clr  = 0;
      m_wrap = 0;
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0;
    end else if (u_if.addr_ready) begin
      m_left--;
      if (u_if.agu_on_j0 && m_wrap < (1 << BWC) - 1) m_wrap++;
      if (m_left == 0) m_fin = 1;
    end
  endtask

  // one clock: check outputs against the model, then advance the model
  task automatic cycle();
    bit run_ph, e_valid, e_step, e_last, e_done, e_clr;
    run_ph  = m_busy && !m_clr && !m_fin;
    e_valid = run_ph && !u_if.abort;
    e_step  = e_valid && u_if.addr_ready;
    e_last  = e_valid && (m_left == 1);
    e_done  = m_fin && !u_if.abort;
    e_clr   = m_busy && m_clr;
    #1;
    chk("start_rdy",  u_if.start_rdy,  !m_busy);
    chk("busy",       u_if.busy,       m_busy);
    chk("agu_clr",    u_if.agu_clr,    e_clr);
    chk("addr_valid", u_if.addr_valid, e_valid);
    chk("agu_step",   u_if.agu_step,   e_step);
    chk("addr_last",  u_if.addr_last,  e_last);
    chk("done",       u_if.done,       e_done);
    chk("agu_l",      u_if.agu_l,      m_l);
    chk("agu_j",      u_if.agu_j,      m_j);
`ifdef AGU_SEQ_WRAPCNT_EN
    chk("wrap_cnt",   u_if.wrap_cnt,   m_wrap);
`endif
    if (u_if.busy) s_busy++;
    if (u_if.agu_clr) s_clr++;
    if (u_if.addr_valid) s_valid++;
    if (u_if.done) begin s_done++; s_done_cyc = cyc; end
    if (u_if.agu_step) begin
      s_xfer++;
      if (u_if.addr_last) begin s_last_idx = s_xfer; s_last_cyc = cyc; end
    end
    @(posedge clk);
    model_update();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit st, input bit ab, input bit rd, input bit j0);
    u_if.start = st; u_if.abort = ab; u_if.addr_ready = rd; u_if.agu_on_j0 = j0;
  endtask

  task automatic rand_cfg();
    for (int i = 1; i < NJ; i++) u_if.cfg_l[i] = BWL'($urandom);
    for (int i = 0; i < NJ; i++) u_if.cfg_j[i] = BWA'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (u_if.busy && k < bound) begin
      cycle();
      k++;
    end
    chk("idle_timeout", u_if.busy, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    u_if.cfg_l = '0; u_if.cfg_j = '0; u_if.cfg_count = '0;
    model_reset();
    clr_stats();
    @(negedge clk);
    #1;
    chk("rst_start_rdy", u_if.start_rdy, 1'b1);
    chk("rst_busy",      u_if.busy,      1'b0);
    chk("rst_agu_j",     u_if.agu_j,     '0);
    chk("rst_agu_l",     u_if.agu_l,     '0);
    chk("rst_valid",     u_if.addr_valid, 1'b0);
    chk("rst_clr",       u_if.agu_clr,   1'b0);
    rst = 1'b0;
    @(negedge clk);

    // basic job, count 6, ready held high
    rand_cfg();
    u_if.cfg_l = {8'd1, 8'd1, 8'd1, 8'd2};
    u_if.cfg_count = 16'd6;
    drive(1, 0, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    clr_stats();
    for (int i = 0; i < 9; i++) cycle();
    chk("basic_busy_len", s_busy, 8);
    chk("basic_xfers",    s_xfer, 6);
    chk("basic_clr",      s_clr, 1);
    chk("basic_last_idx", s_last_idx, 6);
    chk("basic_done_lag", s_done_cyc - s_last_cyc, 1);
    chk("basic_done_cnt", s_done, 1);

    // back-pressure, count 4
    rand_cfg();
    u_if.cfg_count = 16'd4;
    drive(1, 0, 0, 0);
    cycle();
    clr_stats();
    drive(0, 0, 0, 0);
    cycle();
    begin
      bit [6:0] pat;
      pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
      for (int i = 0; i < 7; i++) begin
        drive(0, 0, pat[i], 0);
        cycle();
      end
    end
    chk("bp_xfers", s_xfer, 4);
    chk("bp_last_idx", s_last_idx, 4);
    drive(0, 0, 1, 0);
    wait_idle(10);
    chk("bp_done_cnt", s_done, 1);

    // zero-count job
    u_if.cfg_count = 16'd0;
    drive(1, 0, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    clr_stats();
    cycle();
    cycle();
    chk("zero_clr",   s_clr, 0);
    chk("zero_valid", s_valid, 0);
    chk("zero_done",  s_done, 1);
    chk("zero_rdy",   u_if.start_rdy, 1'b1);

    // abort after 3 transfers, then a clean count-2 job
    rand_cfg();
    u_if.cfg_count = 16'd10;
    drive(1, 0, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    clr_stats();
    for (int i = 0; i < 4; i++) cycle();
    chk("abort_pre_xfers", s_xfer, 3);
    drive(0, 1, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    #1;
    chk("abort_idle", u_if.busy, 1'b0);
    @(negedge clk);
    cycle();
    chk("abort_xfers", s_xfer, 3);
    chk("abort_no_done", s_done, 0);
    rand_cfg();
    u_if.cfg_count = 16'd2;
    drive(1, 0, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    clr_stats();
    wait_idle(10);
    chk("rerun_clr",   s_clr, 1);
    chk("rerun_xfers", s_xfer, 2);
    chk("rerun_done",  s_done, 1);

    // config isolation and async reset mid-RUN
    rand_cfg();
    u_if.cfg_j[4] = 21'd1;
    u_if.cfg_count = 16'd5;
    drive(1, 0, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    cycle();
    cycle();
    u_if.cfg_j[4] = 21'd7;
    drive(1, 0, 1, 0);
    cycle();
    drive(0, 0, 1, 0);
    #1;
    chk("iso_j4", u_if.agu_j[4], 21'd1);
    chk("iso_still_busy", u_if.busy, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy",  u_if.busy,       1'b0);
    chk("arst_valid", u_if.addr_valid, 1'b0);
    chk("arst_step",  u_if.agu_step,   1'b0);
    chk("arst_last",  u_if.addr_last,  1'b0);
    chk("arst_agu_j", u_if.agu_j,      '0);
    chk("arst_agu_l", u_if.agu_l,      '0);
    chk("arst_rdy",   u_if.start_rdy,  1'b1);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);

`ifdef AGU_SEQ_WRAPCNT_EN
    // every step coincides with the outer wrap when all lengths are 0
    u_if.cfg_l = '0;
    u_if.cfg_count = 16'd5;
    drive(1, 0, 1, 1);
    cycle();
    drive(0, 0, 1, 1);
    wait_idle(10);
    chk("wrap_after_done", u_if.wrap_cnt, 5);
    u_if.cfg_count = 16'd3;
    drive(1, 0, 1, 1);
    cycle();
    drive(0, 0, 1, 1);
    cycle();
    chk("wrap_cleared", u_if.wrap_cnt, 0);
    wait_idle(10);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(99) < 25), ($urandom_range(99) < 4),
            ($urandom_range(99) < 70), 1'($urandom_range(1)));
      u_if.cfg_count = ($urandom_range(9) == 0) ? 16'($urandom_range(40))
                                                : 16'($urandom_range(6));
      rand_cfg();
      cycle();
    end
    drive(0, 0, 1, 0);
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
